vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares the single-port video/main RAM between the raster fetcher (video pixel
//  and character-row fetches) and the 6502 CPU bus. Video has priority on each
//  slot; a CPU request that waits too long gets a forced slot (anti-starvation).
//  The arbiter drives the registered memory port and returns read data to the
//  winning requester with a fixed latency.
// PARAMETERS
//  AW        16  address width of all address ports
//  DW         8  data width of all data ports
//  MAX_WAIT   8  CPU wait cycles (1..255) before CPU pre-empts a video request
// PORTS
//  clk        in   1   system clock (pixel clock domain)
//  reset      in   1   asynchronous, active-high reset
//  vid_req    in   1   video fetch request this cycle (sampled every cycle)
//  vid_addr   in   AW  video fetch address, valid with vid_req
//  vid_data   out  DW  video read data, valid when vid_valid=1
//  vid_valid  out  1   1-cycle pulse: vid_data is the result of a granted vid_req
//  vid_miss   out  1   1-cycle pulse: a vid_req was pre-empted; no data returned
//  cpu_req    in   1   CPU access request, level; held with stable addr/we/wdata until cpu_ack
//  cpu_we     in   1   1=write, 0=read
//  cpu_addr   in   AW  CPU address
//  cpu_wdata  in   DW  CPU write data
//  cpu_rdata  out  DW  CPU read data, valid when cpu_ack=1 on a read
//  cpu_ack    out  1   1-cycle pulse: CPU access complete
//  mem_addr   out  AW  registered RAM address
//  mem_we     out  1   registered RAM write enable
//  mem_wdata  out  DW  registered RAM write data
//  mem_rdata  in   DW  RAM read data, valid 1 cycle after mem_addr is presented
// BEHAVIOUR
//  Reset: every output, cpu_busy, wait_cnt and both owner pipeline stages = 0.
//  Slot decision (cycle t, from inputs in t); cpu_elig = cpu_req & ~cpu_busy:
//   - force = cpu_elig & (wait_cnt == MAX_WAIT).
//   - force            -> owner CPU_RD/CPU_WR (by cpu_we); a concurrent vid_req is pre-empted.
//   - vid_req          -> owner VID.
//   - cpu_elig         -> owner CPU_RD/CPU_WR.
//   - otherwise        -> owner NONE; mem_we=0, mem_addr holds its last value.
//  Edge ending t: mem_addr/mem_we/mem_wdata <= granted request (mem_we=1 only for
//   CPU_WR); owner pipeline stage1 <= owner; on CPU grant cpu_busy <= 1.
//  Edge ending t+1: stage2 <= stage1; RAM performs the access.
//  Edge ending t+2, by stage2:
//   VID -> vid_data <= mem_rdata, vid_valid=1.
//   CPU_RD -> cpu_rdata <= mem_rdata, cpu_ack=1.
//   CPU_WR -> cpu_ack=1.
//   All pulse outputs are registered and high for exactly one cycle.
//  Latency: request cycle t -> vid_valid/cpu_ack high in cycle t+3 (registered
//   after edge t+2). Reads and writes have identical latency.
//  cpu_busy clears on the edge that raises cpu_ack. cpu_req still high in the ack
//   cycle is treated as a new request and is eligible in that same cycle.
//  Pre-empted vid_req: a NONE-data marker is carried through the pipeline and
//   vid_miss pulses in t+3 in place of vid_valid. vid_valid and vid_miss are never both 1.
//  wait_cnt (8 bit): cleared on any CPU grant or when cpu_elig=0; incremented
//   when cpu_elig=1 and the slot goes to VID; saturates at MAX_WAIT.
//  Video never waits: vid_req is granted or missed in its own cycle, never queued.
//  Async reset mid-access: in-flight acks/valids are discarded (no pulse after
//   reset release); the CPU must re-issue after reset.
// TESTING
//  1 Reset: assert reset mid-stream -> all outputs 0 immediately; no cpu_ack/vid_valid after release.
//  2 Video only: vid_req=1 every cycle, addrs 0x1000..0x1007, RAM=addr[7:0]
//    -> vid_valid each cycle from t+3, vid_data 0x00..0x07 in order.
//  3 CPU idle bus: write 0xA5 @0x0200, then read @0x0200 -> mem_we=1 one cycle;
//    cpu_ack at t+3; read returns cpu_rdata=0xA5 at t+3.
//  4 Contention, MAX_WAIT=8: vid_req=1 continuously, CPU read 0x9000 -> 8 VID
//    grants, 9th slot CPU, exactly one vid_miss, cpu_ack 3 cycles after the forced grant.
//  5 Back-to-back CPU: cpu_req held through ack with a new addr -> second grant in
//    the ack cycle; no duplicate grant while cpu_busy=1.
//  6 Alternating vid_req (hc[0] pattern) + CPU req -> CPU served in the idle slot,
//    zero vid_miss, wait_cnt never exceeds 1.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Video fetcher, CPU bus and RAM port of the shared video/main RAM arbiter.
// slave = arbiter side; master = requesters plus RAM (as driven by a bench).
interface vram_arbiter_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic [DW-1:0] vid_data;
   logic          vid_valid;
   logic          vid_miss;

   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;

   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      output vid_data, vid_valid, vid_miss, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
      input  vid_data, vid_valid, vid_miss, cpu_rdata, cpu_ack, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/vram_arbiter.sv
// Shares one RAM port: video wins each slot, CPU forced in after MAX_WAIT lost slots; 3-cycle request->valid/ack.
// Video never stalls (pre-empted fetch reports vid_miss); CPU holds cpu_req level until its cpu_ack pulse.
module vram_arbiter #(
   parameter int AW       = 16,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 8
) (
   input logic           clk,
   input logic           reset,
   vram_arbiter_if.slave bus
);
   typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU_RD, OWN_CPU_WR} owner_t;

   typedef struct packed {
      owner_t owner;
      logic   miss;
   } slot_t;

   localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

   owner_t        owner;
   owner_t        cpu_own;
   logic          miss;
   logic          cpu_elig;
   logic          force_cpu;
   logic          cpu_grant;
   logic          stage2_cpu;
   slot_t         stage1;
   slot_t         stage2;
   logic          cpu_busy;
   logic [7:0]    wait_cnt;

   logic [AW-1:0] mem_addr_q;
   logic          mem_we_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] vid_data_q;
   logic [DW-1:0] cpu_rdata_q;
   logic          vid_valid_q;
   logic          vid_miss_q;
   logic          cpu_ack_q;

   assign cpu_elig   = bus.cpu_req & ~cpu_busy;
   assign force_cpu  = cpu_elig & (wait_cnt == MAX_W);
   assign cpu_own    = bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
   assign cpu_grant  = (owner == OWN_CPU_RD) || (owner == OWN_CPU_WR);
   assign stage2_cpu = (stage2.owner == OWN_CPU_RD) || (stage2.owner == OWN_CPU_WR);

   always_comb begin
      owner = OWN_NONE;
      miss  = 1'b0;
      if (force_cpu) begin
         owner = cpu_own;
         miss  = bus.vid_req;
      end else if (bus.vid_req) begin
         owner = OWN_VID;
      end else if (cpu_elig) begin
         owner = cpu_own;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr_q  <= '0;
         mem_we_q    <= 1'b0;
         mem_wdata_q <= '0;
         vid_data_q  <= '0;
         cpu_rdata_q <= '0;
         vid_valid_q <= 1'b0;
         vid_miss_q  <= 1'b0;
         cpu_ack_q   <= 1'b0;
         stage1      <= '0;
         stage2      <= '0;
         cpu_busy    <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         // Address and write data hold their last value on idle slots.
         mem_we_q <= 1'b0;
         case (owner)
            OWN_VID: mem_addr_q <= bus.vid_addr;
            OWN_CPU_RD, OWN_CPU_WR: begin
               mem_addr_q  <= bus.cpu_addr;
               mem_wdata_q <= bus.cpu_wdata;
               mem_we_q    <= (owner == OWN_CPU_WR);
            end
            default: ;
         endcase

         stage1 <= '{owner: owner, miss: miss};
         stage2 <= stage1;

         vid_valid_q <= (stage2.owner == OWN_VID);
         vid_miss_q  <= stage2.miss;
         cpu_ack_q   <= stage2_cpu;
         if (stage2.owner == OWN_VID)    vid_data_q  <= bus.mem_rdata;
         if (stage2.owner == OWN_CPU_RD) cpu_rdata_q <= bus.mem_rdata;

         // Busy drops on the ack edge so a still-high cpu_req counts as a new request.
         if (stage2_cpu)     cpu_busy <= 1'b0;
         else if (cpu_grant) cpu_busy <= 1'b1;

         if (cpu_grant || !cpu_elig)                   wait_cnt <= '0;
         else if (owner == OWN_VID && wait_cnt != MAX_W) wait_cnt <= wait_cnt + 8'd1;
      end
   end

   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.vid_data  = vid_data_q;
   assign bus.vid_valid = vid_valid_q;
   assign bus.vid_miss  = vid_miss_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.cpu_ack   = cpu_ack_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: behavioural RAM, per-cycle stimulus with hand-computed expectations.
module tb_vram_arbiter;
   localparam int AW = 16;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset;
   int   n_run  = 0;
   int   n_fail = 0;

   logic [7:0] ram     [0:65535];
   bit         written [0:65535];

   vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   vram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Unwritten locations read as addr[7:0], except 0x9000 which reads 0x5C.
   function automatic logic [7:0] ram_init(input logic [15:0] a);
      return (a == 16'h9000) ? 8'h5C : a[7:0];
   endfunction

   always @(posedge clk) begin
      if (bus.mem_we) begin
         ram[bus.mem_addr]     <= bus.mem_wdata;
         written[bus.mem_addr] <= 1'b1;
      end
      bus.mem_rdata <= written[bus.mem_addr] ? ram[bus.mem_addr] : ram_init(bus.mem_addr);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset         = 1'b0;
      bus.vid_req   = 1'b0;
      bus.vid_addr  = '0;
      bus.cpu_req   = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      #2 reset = 1'b1;
      #1;
      chk("rst vid_valid", 32'(bus.vid_valid), 32'd0);
      chk("rst vid_miss",  32'(bus.vid_miss),  32'd0);
      chk("rst cpu_ack",   32'(bus.cpu_ack),   32'd0);
      chk("rst mem_we",    32'(bus.mem_we),    32'd0);
      chk("rst mem_addr",  32'(bus.mem_addr),  32'd0);
      repeat (2) step();
      reset = 1'b0;

      // Video only: addresses 0x1000.. stream back 0x00.. three cycles later.
      for (int k = 0; k <= 10; k++) begin
         step();
         chk($sformatf("vid valid k=%0d", k), 32'(bus.vid_valid), 32'(k >= 3));
         chk($sformatf("vid miss k=%0d", k), 32'(bus.vid_miss), 32'd0);
         if (k >= 3) chk($sformatf("vid data k=%0d", k), 32'(bus.vid_data), 32'(k - 3));
         bus.vid_req  = (k < 8);
         bus.vid_addr = 16'(16'h1000 + k);
      end

      // CPU on an idle bus: write 0xA5 @0x0200, then read it back.
      for (int k = 0; k <= 8; k++) begin
         step();
         chk($sformatf("cpu mem_we k=%0d", k), 32'(bus.mem_we), 32'(k == 1));
         chk($sformatf("cpu ack k=%0d", k), 32'(bus.cpu_ack), 32'(k == 3 || k == 7));
         if (k == 1) begin
            chk("cpu wr mem_addr",  32'(bus.mem_addr),  32'h0200);
            chk("cpu wr mem_wdata", 32'(bus.mem_wdata), 32'hA5);
         end
         if (k == 5) chk("cpu rd mem_addr", 32'(bus.mem_addr), 32'h0200);
         if (k == 7) chk("cpu rd rdata", 32'(bus.cpu_rdata), 32'hA5);
         if (k == 0) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0200; bus.cpu_wdata = 8'hA5;
         end
         if (k == 3) bus.cpu_req = 1'b0;
         if (k == 4) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0200;
         end
         if (k == 7) bus.cpu_req = 1'b0;
      end

      // Contention: 8 video grants, forced CPU slot on the 9th, one miss.
      for (int k = 0; k <= 15; k++) begin
         step();
         chk($sformatf("cont valid k=%0d", k), 32'(bus.vid_valid),
             32'((k >= 3 && k <= 10) || k >= 12));
         if ((k >= 3 && k <= 10) || k >= 12)
            chk($sformatf("cont data k=%0d", k), 32'(bus.vid_data), 32'(k - 3));
         chk($sformatf("cont miss k=%0d", k), 32'(bus.vid_miss), 32'(k == 11));
         chk($sformatf("cont ack k=%0d", k), 32'(bus.cpu_ack), 32'(k == 11));
         if (k == 9)  chk("cont mem_addr", 32'(bus.mem_addr), 32'h9000);
         if (k == 11) chk("cont rdata", 32'(bus.cpu_rdata), 32'h5C);
         bus.vid_req  = (k < 13);
         bus.vid_addr = 16'(16'h1000 + k);
         if (k == 0) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h9000;
         end
         if (k == 11) bus.cpu_req = 1'b0;
      end

      // Back-to-back CPU reads: second grant in the ack cycle, none while busy.
      for (int k = 0; k <= 8; k++) begin
         step();
         chk($sformatf("b2b ack k=%0d", k), 32'(bus.cpu_ack), 32'(k == 3 || k == 6));
         if (k >= 1) chk($sformatf("b2b mem_addr k=%0d", k), 32'(bus.mem_addr),
                         (k <= 3) ? 32'h9000 : 32'h0200);
         if (k == 3) chk("b2b rdata1", 32'(bus.cpu_rdata), 32'h5C);
         if (k == 6) chk("b2b rdata2", 32'(bus.cpu_rdata), 32'hA5);
         if (k == 0) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h9000;
         end
         if (k == 3) bus.cpu_addr = 16'h0200;
         if (k == 6) bus.cpu_req = 1'b0;
      end

      // Alternating video slots: CPU write takes the idle slot, no miss.
      for (int k = 0; k <= 10; k++) begin
         step();
         chk($sformatf("alt valid k=%0d", k), 32'(bus.vid_valid),
             32'(k == 3 || k == 5 || k == 7 || k == 9));
         if (k == 3 || k == 5 || k == 7 || k == 9)
            chk($sformatf("alt data k=%0d", k), 32'(bus.vid_data), 32'(k - 3));
         chk($sformatf("alt miss k=%0d", k), 32'(bus.vid_miss), 32'd0);
         chk($sformatf("alt ack k=%0d", k), 32'(bus.cpu_ack), 32'(k == 4));
         chk($sformatf("alt mem_we k=%0d", k), 32'(bus.mem_we), 32'(k == 2));
         if (k == 2) begin
            chk("alt mem_addr",  32'(bus.mem_addr),  32'h0300);
            chk("alt mem_wdata", 32'(bus.mem_wdata), 32'h3C);
         end
         bus.vid_req  = (k < 7) && (k % 2 == 0);
         bus.vid_addr = 16'(16'h1000 + k);
         if (k == 0) begin
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0300; bus.cpu_wdata = 8'h3C;
         end
         if (k == 4) bus.cpu_req = 1'b0;
      end

      // Reset mid-stream: outputs clear at once, in-flight pulses are dropped.
      step();
      bus.vid_req = 1'b1; bus.vid_addr = 16'h1000;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h9000;
      repeat (2) step();
      #2 reset = 1'b1;
      #1;
      chk("mid rst vid_valid", 32'(bus.vid_valid), 32'd0);
      chk("mid rst vid_miss",  32'(bus.vid_miss),  32'd0);
      chk("mid rst vid_data",  32'(bus.vid_data),  32'd0);
      chk("mid rst cpu_ack",   32'(bus.cpu_ack),   32'd0);
      chk("mid rst cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      chk("mid rst mem_we",    32'(bus.mem_we),    32'd0);
      chk("mid rst mem_addr",  32'(bus.mem_addr),  32'd0);
      chk("mid rst mem_wdata", 32'(bus.mem_wdata), 32'd0);
      bus.vid_req = 1'b0;
      bus.cpu_req = 1'b0;
      repeat (2) step();
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk($sformatf("post rst ack k=%0d", k),   32'(bus.cpu_ack),   32'd0);
         chk($sformatf("post rst valid k=%0d", k), 32'(bus.vid_valid), 32'd0);
         chk($sformatf("post rst miss k=%0d", k),  32'(bus.vid_miss),  32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
